// File: rtl/ysyx_24090012_pkg.sv
// Shared types and constants for the ysyx_24090012 instruction fetch unit.
package ysyx_24090012_pkg;

  // Fetch sequencing: request, wait for data, hand off to IDU, wait for commit.
  typedef enum logic [1:0] {
    REQ      = 2'd0,
    WAIT     = 2'd1,
    SEND     = 2'd2,
    WAIT_NPC = 2'd3
  } ifu_state_t;

  // addi x0, x0, 0 -- delivered in place of a fetch from a misaligned PC.
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24090012_ifu_if.sv
// Bundle of the IFU's memory, IDU handoff, commit and performance signals.
interface ysyx_24090012_ifu_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        ifu_valid;
  logic        idu_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_err;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] perf_fetch_cnt;

  // The IFU side drives requests and the IDU payload.
  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_err,
    output ifu_valid, inst, pc, fetch_err,
    input  idu_ready,
    input  npc_valid, npc,
    output perf_fetch_cnt
  );

  // Memory, IDU and commit stage seen from the surrounding core.
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_err,
    input  ifu_valid, inst, pc, fetch_err,
    output idu_ready,
    output npc_valid, npc,
    input  perf_fetch_cnt
  );

endinterface

// File: rtl/ysyx_24090012_ifu.sv
// Instruction fetch unit: one instruction in flight, fetched from memory,
// handed to the IDU, then held until commit supplies the next PC.
module ysyx_24090012_ifu
  import ysyx_24090012_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24090012_ifu_if.master         bus
);

  ifu_state_t  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fetchErr_q;
  logic [31:0] perfCnt_q;
  logic [31:0] perfCnt_d;

  // Delivered-instruction counter simply wraps at 32 bits.
  assign perfCnt_d = perfCnt_q + 32'd1;

  // Every output is either a state decode or a register, never an input.
  assign bus.mem_req_valid  = (state_q == REQ);
  assign bus.mem_req_addr   = pc_q;
  assign bus.ifu_valid      = (state_q == SEND);
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.fetch_err      = fetchErr_q;
  assign bus.perf_fetch_cnt = perfCnt_q;

  // Fetch FSM together with the PC, instruction, fault and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      fetchErr_q <= 1'b0;
      perfCnt_q  <= '0;
    end else begin
      case (state_q)
        REQ: begin
          if (bus.mem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            inst_q     <= bus.mem_resp_data;
            fetchErr_q <= bus.mem_resp_err;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (bus.idu_ready) begin
            perfCnt_q <= perfCnt_d;
            state_q   <= WAIT_NPC;
          end
        end
        WAIT_NPC: begin
          if (bus.npc_valid) begin
            pc_q <= bus.npc;
            if (bus.npc[1:0] == 2'b00) begin
              state_q <= REQ;
            end else begin
              inst_q     <= INST_NOP;
              fetchErr_q <= 1'b1;
              state_q    <= SEND;
            end
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  // A commit pulse while no instruction is awaiting one indicates a core bug.
  npcOnlyInWaitNpc: assert property (@(posedge clk) disable iff (!rst)
    bus.npc_valid |-> (state_q == WAIT_NPC));

endmodule

// File: doc/ysyx_24090012_ifu.md
# ysyx_24090012_ifu

Instruction fetch unit of the multi-cycle NPC core. Holds the architectural PC, issues one 32-bit instruction read per instruction to instruction memory over a valid/ready request and response channel, and presents `{inst, pc}` to the IDU on the `ifu_valid`/`idu_ready` handshake. It then waits for the commit-stage next-PC before fetching again, so exactly one instruction is in flight in the core.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded at reset.
- `clk` input 1: core clock.
- `rst` input 1: asynchronous, active-low reset.
- `mem_req_valid` output 1: fetch request valid.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_addr` output 32: word-aligned fetch address.
- `mem_resp_valid` input 1: read data valid, one-cycle pulse.
- `mem_resp_data` input 32: instruction word.
- `mem_resp_err` input 1: access fault, qualified by `mem_resp_valid`.
- `ifu_valid` output 1: `inst`/`pc` valid toward the IDU.
- `idu_ready` input 1: IDU accepts.
- `inst` output 32: fetched instruction.
- `pc` output 32: address of `inst`.
- `fetch_err` output 1: the instruction carries a fetch fault (access or misaligned). Valid with `ifu_valid`.
- `npc_valid` input 1: commit pulse carrying the next PC.
- `npc` input 32: next PC to fetch.
- `perf_fetch_cnt` output 32: count of instructions delivered to the IDU.

## Operation
- FSM states:
  - REQ: `mem_req_valid`=1. On `mem_req_ready`, go to WAIT.
  - WAIT: on `mem_resp_valid`, latch `inst`←`mem_resp_data` and `fetch_err`←`mem_resp_err`, then go to SEND.
  - SEND: `ifu_valid`=1. On `idu_ready`, increment `perf_fetch_cnt` and go to WAIT_NPC.
  - WAIT_NPC: on `npc_valid`, set PC←`npc`.
    - If `npc[1:0]`==0, go to REQ.
    - Otherwise load `inst`=32'h0000_0013 (NOP) and `fetch_err`=1, and go directly to SEND with no memory access.
- `mem_req_addr` = `pc` at all times. `pc` changes only on the WAIT_NPC transition.
- In SEND, `inst`, `pc` and `fetch_err` stay stable until the handshake completes. `ifu_valid` never drops without `idu_ready`.
- `mem_resp_valid` outside WAIT is ignored. `npc_valid` outside WAIT_NPC is ignored; simulation-only assertion flags it.
- `perf_fetch_cnt` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - state = REQ
  - `pc` = RESET_PC
  - `inst` = 0
  - `fetch_err` = 0
  - `ifu_valid` = 0
  - `perf_fetch_cnt` = 0
  - `mem_req_valid` = 1 in the first cycle after `rst` deasserts.
- All outputs are decoded from state or come from registers. There are no combinational paths from inputs to outputs.
- Memory response is earliest the cycle after request acceptance; it is never sampled in REQ.
- Minimum latency: `mem_req_ready` at cycle k, `mem_resp_valid` at k+1, `ifu_valid` at k+2.
- Handshake at cycle s: `ifu_valid` is low at s+1. `npc_valid` at cycle t gives `mem_req_valid` high with the new address at t+1.
- `rst` asserted in any state forces reset values immediately, including mid-request and mid-handoff. A pending memory response is dropped because memory is reset on the same `rst`.

## Structure
- Shared package `ysyx_24090012_pkg`:
  - `ifu_state_t` (REQ, WAIT, SEND, WAIT_NPC)
  - `INST_NOP` = 32'h0000_0013
  - `RESET_PC_DEFAULT`
- Single flat module. No sub-module is warranted.

## Test plan
- Reset release, memory ready immediately, response 32'h0010_0093 next cycle: `mem_req_addr`=8000_0000, `ifu_valid` two cycles after acceptance, `inst`=0010_0093, `pc`=8000_0000.
- `idu_ready` held low 5 cycles in SEND: `ifu_valid`, `inst` and `pc` stable throughout. `perf_fetch_cnt` goes 0→1 only on the accepting edge.
- `npc_valid` with `npc`=8000_0010, then `mem_req_ready` low 3 cycles: `mem_req_valid` held with addr 8000_0010 until accepted.
- `mem_resp_err`=1 with data 0xDEADBEEF: SEND shows `fetch_err`=1 and `inst`=DEADBEEF. The next fetch after `npc` clears `fetch_err`.
- `npc`=8000_0006: no `mem_req_valid`, next cycle `ifu_valid`=1, `inst`=0000_0013, `fetch_err`=1, `pc`=8000_0006.
- `rst` asserted in WAIT, then a stray `mem_resp_valid` after release: state is REQ, `pc`=RESET_PC, the stray response is ignored, and the counter wraps correctly when preloaded to FFFF_FFFF by force.
